// File: rtl/control_nivel_vehiculos.sv
// Level controller for the vehicle stage: per-level shift strobe prescaler,
// level advance when the frog reaches the goal, sticky victory after the last level.
module control_nivel_vehiculos #(
    parameter int DATAWIDTH_CNT    = 26,
    parameter int DATAWIDTH_NVL    = 2,
    parameter int DATAWIDTH_ESTADO = 3,
    parameter int PERIODO_NV1      = 25_000_000,
    parameter int PERIODO_NV2      = 18_750_000,
    parameter int PERIODO_NV3      = 12_500_000,
    parameter int PERIODO_NV4      = 6_250_000,
    parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_INICIO = 3'b000,
    parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_JUEGO  = 3'b001
) (
    input  logic                        CNV_CLOCK,
    input  logic                        CNV_RESET,
    input  logic [DATAWIDTH_ESTADO-1:0] CNV_ESTADO_IN,
    input  logic                        CNV_META_IN,
    input  logic                        CNV_CHOQUE_IN,
    output logic [DATAWIDTH_NVL-1:0]    CNV_NV_OUT,
    output logic                        CNV_CN_OUT,
    output logic                        CNV_CARGA_OUT,
    output logic                        CNV_VICTORIA_OUT
);

    // state  | meaning
    // ESPERA | paused or new game; counter held
    // CORRE  | playing; prescaler running, CN on terminal count
    // CAMBIO | one-cycle level transition; lanes reloading
    // FIN    | last level completed; waits for a new game
    typedef enum logic [1:0] {ESPERA, CORRE, CAMBIO, FIN} fsm_t;

    localparam logic [DATAWIDTH_CNT-1:0] TC_NV1 = DATAWIDTH_CNT'(PERIODO_NV1 - 1);
    localparam logic [DATAWIDTH_CNT-1:0] TC_NV2 = DATAWIDTH_CNT'(PERIODO_NV2 - 1);
    localparam logic [DATAWIDTH_CNT-1:0] TC_NV3 = DATAWIDTH_CNT'(PERIODO_NV3 - 1);
    localparam logic [DATAWIDTH_CNT-1:0] TC_NV4 = DATAWIDTH_CNT'(PERIODO_NV4 - 1);
    localparam logic [DATAWIDTH_NVL-1:0] NV_ULTIMO = '1;

    fsm_t                     fsm, fsm_next;
    logic [DATAWIDTH_CNT-1:0] cnt, cnt_next;
    logic [DATAWIDTH_NVL-1:0] nivel, nivel_next;
    logic                     cn, cn_next;
    logic                     carga, carga_next;
    logic                     victoria, victoria_next;
    logic                     inicio_d;
    logic [DATAWIDTH_CNT-1:0] tc;
    logic                     es_inicio, es_juego;

    assign es_inicio = (CNV_ESTADO_IN == ESTADO_INICIO);
    assign es_juego  = (CNV_ESTADO_IN == ESTADO_JUEGO);

    always_comb begin
        tc = TC_NV4;
        case (nivel)
            DATAWIDTH_NVL'(0): tc = TC_NV1;
            DATAWIDTH_NVL'(1): tc = TC_NV2;
            DATAWIDTH_NVL'(2): tc = TC_NV3;
            default:           tc = TC_NV4;
        endcase
    end

    always_comb begin
        fsm_next      = fsm;
        cnt_next      = cnt;
        nivel_next    = nivel;
        cn_next       = 1'b0;
        carga_next    = 1'b0;
        victoria_next = victoria;
        if (es_inicio) begin
            // Reload pulse only on the first INICIO cycle, even if INICIO is held.
            fsm_next      = ESPERA;
            cnt_next      = '0;
            nivel_next    = '0;
            victoria_next = 1'b0;
            carga_next    = ~inicio_d;
        end else begin
            case (fsm)
                ESPERA: begin
                    if (es_juego)
                        fsm_next = CORRE;
                end
                CORRE: begin
                    if (!es_juego) begin
                        fsm_next = ESPERA;
                    end else if (CNV_CHOQUE_IN) begin
                        cnt_next = '0;
                    end else if (CNV_META_IN) begin
                        cnt_next = '0;
                        if (nivel == NV_ULTIMO) begin
                            fsm_next      = FIN;
                            victoria_next = 1'b1;
                        end else begin
                            fsm_next   = CAMBIO;
                            nivel_next = nivel + DATAWIDTH_NVL'(1);
                            carga_next = 1'b1;
                        end
                    end else if (cnt == tc) begin
                        cnt_next = '0;
                        cn_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + DATAWIDTH_CNT'(1);
                    end
                end
                CAMBIO: begin
                    cnt_next = '0;
                    fsm_next = es_juego ? CORRE : ESPERA;
                end
                FIN: begin
                    cnt_next = '0;
                end
                default: begin
                    fsm_next = ESPERA;
                    cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CNV_CLOCK or posedge CNV_RESET) begin
        if (CNV_RESET) begin
            fsm      <= ESPERA;
            cnt      <= '0;
            nivel    <= '0;
            cn       <= 1'b0;
            carga    <= 1'b0;
            victoria <= 1'b0;
            inicio_d <= 1'b0;
        end else begin
            fsm      <= fsm_next;
            cnt      <= cnt_next;
            nivel    <= nivel_next;
            cn       <= cn_next;
            carga    <= carga_next;
            victoria <= victoria_next;
            inicio_d <= es_inicio;
        end
    end

    assign CNV_NV_OUT       = nivel;
    assign CNV_CN_OUT       = cn;
    assign CNV_CARGA_OUT    = carga;
    assign CNV_VICTORIA_OUT = victoria;

endmodule

// File: tb/tb_control_nivel_vehiculos.sv
// Bench for control_nivel_vehiculos: directed scenarios with literal expectations,
// then randomized play compared every cycle against a cycles-remaining reference model.
module tb_control_nivel_vehiculos;

    localparam logic [2:0] INICIO = 3'b000;
    localparam logic [2:0] JUEGO  = 3'b001;
    localparam logic [2:0] OTRO   = 3'b010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] estado = INICIO;
    logic       meta = 1'b0;
    logic       choque = 1'b0;
    logic [1:0] nv;
    logic       cn, carga, victoria;

    int errors = 0;
    int checks = 0;

    control_nivel_vehiculos #(
        .DATAWIDTH_CNT(26), .DATAWIDTH_NVL(2), .DATAWIDTH_ESTADO(3),
        .PERIODO_NV1(8), .PERIODO_NV2(6), .PERIODO_NV3(4), .PERIODO_NV4(2),
        .ESTADO_INICIO(3'b000), .ESTADO_JUEGO(3'b001)
    ) dut (
        .CNV_CLOCK(clk),
        .CNV_RESET(rst),
        .CNV_ESTADO_IN(estado),
        .CNV_META_IN(meta),
        .CNV_CHOQUE_IN(choque),
        .CNV_NV_OUT(nv),
        .CNV_CN_OUT(cn),
        .CNV_CARGA_OUT(carga),
        .CNV_VICTORIA_OUT(victoria)
    );

    always #5 clk = ~clk;

    // Reference model: level, victory flag, and cycles left until the next strobe.
    localparam int M_IDLE = 0, M_RUN = 1, M_RELOAD = 2, M_DONE = 3;
    int m_mode, m_lvl, m_left;
    bit m_won, m_cn, m_carga, m_prev_ini;

    function automatic int periodo(input int l);
        case (l)
            0: return 8;
            1: return 6;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_lvl = 0; m_left = periodo(0);
            m_won = 0; m_cn = 0; m_carga = 0; m_prev_ini = 0;
        end else begin
            m_cn = 0;
            m_carga = 0;
            if (estado == INICIO) begin
                m_carga = !m_prev_ini;
                m_lvl = 0; m_won = 0; m_mode = M_IDLE; m_left = periodo(0);
            end else if (m_mode == M_IDLE) begin
                if (estado == JUEGO) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (estado != JUEGO) m_mode = M_IDLE;
                else if (choque) m_left = periodo(m_lvl);
                else if (meta && m_lvl == 3) begin
                    m_won = 1; m_mode = M_DONE;
                end else if (meta) begin
                    m_lvl++; m_carga = 1; m_mode = M_RELOAD; m_left = periodo(m_lvl);
                end else if (m_left == 1) begin
                    m_cn = 1; m_left = periodo(m_lvl);
                end else m_left--;
            end else if (m_mode == M_RELOAD) begin
                m_mode = (estado == JUEGO) ? M_RUN : M_IDLE;
            end
            m_prev_ini = (estado == INICIO);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("nv_model", int'(nv), m_lvl);
        chk("cn_model", int'(cn), int'(m_cn));
        chk("carga_model", int'(carga), int'(m_carga));
        chk("victoria_model", int'(victoria), int'(m_won));
        if (cn && carga) chk("cn_carga_exclusive", 1, 0);
    end

    task automatic cyc(input logic [2:0] e, input logic m, input logic c);
        estado = e; meta = m; choque = c;
        @(posedge clk);
        #1;
        meta = 1'b0; choque = 1'b0;
    endtask

    task automatic wait_cn(output int n);
        n = 0;
        do begin
            cyc(JUEGO, 1'b0, 1'b0);
            n++;
        end while (cn !== 1'b1 && n < 50);
        if (cn !== 1'b1) chk("cn_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, cnt_cn, r;
        #1;
        chk("reset_nv", int'(nv), 0);
        chk("reset_cn", int'(cn), 0);
        chk("reset_carga", int'(carga), 0);
        chk("reset_victoria", int'(victoria), 0);
        #11 rst = 1'b0;
        @(posedge clk); #1;
        chk("inicio_carga", int'(carga), 1);
        cyc(INICIO, 0, 0);
        chk("inicio_carga_once", int'(carga), 0);

        // Level 1 free run: strobes after edges 9, 17, 25, 33.
        first = 0; cnt_cn = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(JUEGO, 0, 0);
            if (cn) begin
                cnt_cn++;
                if (first == 0) first = i;
            end
        end
        chk("first_cn_cycle", first, 9);
        chk("cn_count_40", cnt_cn, 4);
        wait_cn(n);
        chk("cn_after_40", n, 1);

        // Pause at counter 5, resume keeps phase.
        for (int i = 0; i < 5; i++) cyc(JUEGO, 0, 0);
        for (int i = 0; i < 10; i++) cyc(OTRO, i == 4, i == 6);
        wait_cn(n);
        chk("pause_phase", n, 4);
        chk("pause_nv", int'(nv), 0);

        // Collision beats goal; collision at counter 7 restarts the period.
        cyc(JUEGO, 1, 1);
        chk("choque_meta_nv", int'(nv), 0);
        chk("choque_meta_carga", int'(carga), 0);
        for (int i = 0; i < 7; i++) cyc(JUEGO, 0, 0);
        cyc(JUEGO, 0, 1);
        chk("choque_tc_cn", int'(cn), 0);
        wait_cn(n);
        chk("choque_restart", n, 8);

        // Goal coinciding with terminal count.
        for (int i = 0; i < 7; i++) cyc(JUEGO, 0, 0);
        cyc(JUEGO, 1, 0);
        chk("meta_tc_cn", int'(cn), 0);
        chk("meta_tc_carga", int'(carga), 1);
        chk("meta_nv1", int'(nv), 1);
        cyc(JUEGO, 0, 0);
        chk("cambio_carga_end", int'(carga), 0);
        wait_cn(n);
        chk("period_nv2", n, 6);

        cyc(JUEGO, 1, 0);
        chk("meta_nv2", int'(nv), 2);
        cyc(JUEGO, 0, 0);
        wait_cn(n);
        chk("period_nv3", n, 4);
        cyc(JUEGO, 1, 0);
        chk("meta_nv3", int'(nv), 3);
        cyc(JUEGO, 0, 0);
        wait_cn(n);
        chk("period_nv4", n, 2);
        cyc(JUEGO, 1, 0);
        chk("victoria_set", int'(victoria), 1);
        chk("victoria_nv", int'(nv), 3);
        chk("victoria_carga", int'(carga), 0);
        cnt_cn = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(JUEGO, i == 3, i == 5);
            if (cn) cnt_cn++;
        end
        chk("fin_no_cn", cnt_cn, 0);
        cyc(INICIO, 0, 0);
        chk("new_game_nv", int'(nv), 0);
        chk("new_game_victoria", int'(victoria), 0);
        chk("new_game_carga", int'(carga), 1);
        cyc(OTRO, 0, 0);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            cyc((r < 3) ? INICIO : (r < 10) ? OTRO : JUEGO,
                $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end

        // Asynchronous reset between edges, mid-count.
        cyc(INICIO, 0, 0);
        for (int i = 0; i < 5; i++) cyc(JUEGO, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_nv", int'(nv), 0);
        chk("async_rst_cn", int'(cn), 0);
        chk("async_rst_carga", int'(carga), 0);
        chk("async_rst_victoria", int'(victoria), 0);
        #3 rst = 1'b0;
        cyc(JUEGO, 0, 0);
        chk("post_rst_cn", int'(cn), 0);
        wait_cn(n);
        chk("post_rst_first_cn", n, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
